// File: rtl/expansion_rom_arbiter.sv
// Expansion ROM arbiter: tracks which agent owns the shared $C800-$CFFF window,
// holds the IIe INTCXROM / SLOTC3ROM / INTC8ROM soft switches, and decodes the
// per-slot ROM enables and internal-ROM select for the current CPU address.
module expansion_rom_arbiter #(
    parameter bit         IIE_MODE     = 1'b1,
    parameter logic [6:0] SLOT_C8_MASK = 7'h02
) (
    input  logic        CLK_14M,
    input  logic        RESET,
    input  logic        PH_2,
    input  logic [15:0] ADDRESS,
    input  logic        RW_N,
    output logic [6:0]  SLOT_ROM_EN,
    output logic [2:0]  C8_OWNER,
    output logic        INT_ROM_SEL,
    output logic        INTCXROM,
    output logic        SLOTC3ROM,
    output logic        INTC8ROM,
    output logic        STAT_VALID,
    output logic        STAT_BIT7
);

    typedef enum logic [1:0] {
        OWN_NONE,
        OWN_SLOT,
        OWN_INTERNAL
    } ownState_t;

    ownState_t  ownState_q, ownState_d;
    logic [2:0] c8Owner_q, c8Owner_d;
    logic       intC8Rom_q, intC8Rom_d;
    logic       intCxRom_q, intCxRom_d;
    logic       slotC3Rom_q, slotC3Rom_d;
    logic       ph2D_q;
    logic       stb;

    logic       inCn;
    logic       inC8;
    logic       inC3;
    logic [2:0] cnSlot;
    logic [7:0] c8MaskExt;
    logic       intCxWrite;
    logic       slotC3Write;
    logic       isCfff;

    // Address decode shared by the state update and the output enables.
    // The mask is widened with a dummy bit 0 so it can be indexed by slot number.
    assign inCn        = (ADDRESS[15:11] == 5'b11000) && (ADDRESS[10:8] != 3'd0);
    assign inC8        = (ADDRESS[15:11] == 5'b11001);
    assign inC3        = (ADDRESS[15:8] == 8'hC3);
    assign cnSlot      = ADDRESS[10:8];
    assign c8MaskExt   = {SLOT_C8_MASK, 1'b0};
    assign isCfff      = (ADDRESS == 16'hCFFF);
    assign intCxWrite  = IIE_MODE && !RW_N && (ADDRESS[15:1] == 15'h6003);
    assign slotC3Write = IIE_MODE && !RW_N && (ADDRESS[15:1] == 15'h6005);

    // One strobe per bus cycle, on the clock following the PH_2 falling edge.
    assign stb = ph2D_q && !PH_2;

    // Next-state for the switches and window owner; only the strobe cycle may
    // change anything, and the branches are ordered by priority.
    always_comb begin
        ownState_d  = ownState_q;
        c8Owner_d   = c8Owner_q;
        intC8Rom_d  = intC8Rom_q;
        intCxRom_d  = intCxRom_q;
        slotC3Rom_d = slotC3Rom_q;
        if (stb) begin
            if (isCfff) begin
                ownState_d = OWN_NONE;
                c8Owner_d  = 3'd0;
                intC8Rom_d = 1'b0;
            end else if (intCxWrite) begin
                intCxRom_d = ADDRESS[0];
            end else if (slotC3Write) begin
                slotC3Rom_d = ADDRESS[0];
            end else if (inCn && !intCxRom_q) begin
                if (inC3 && !slotC3Rom_q) begin
                    ownState_d = OWN_INTERNAL;
                    c8Owner_d  = 3'd0;
                    intC8Rom_d = 1'b1;
                end else if (c8MaskExt[cnSlot]) begin
                    ownState_d = OWN_SLOT;
                    c8Owner_d  = cnSlot;
                    intC8Rom_d = 1'b0;
                end
            end
        end
    end

    // State registers; synchronous reset wins over a coincident strobe and
    // drops window ownership at once. Without IIE_MODE the switches stay at
    // their reset values because the write decodes never fire.
    always_ff @(posedge CLK_14M) begin
        if (RESET) begin
            ph2D_q      <= 1'b0;
            ownState_q  <= OWN_NONE;
            c8Owner_q   <= 3'd0;
            intC8Rom_q  <= 1'b0;
            intCxRom_q  <= 1'b0;
            slotC3Rom_q <= !IIE_MODE;
        end else begin
            ph2D_q      <= PH_2;
            ownState_q  <= ownState_d;
            c8Owner_q   <= c8Owner_d;
            intC8Rom_q  <= intC8Rom_d;
            intCxRom_q  <= intCxRom_d;
            slotC3Rom_q <= slotC3Rom_d;
        end
    end

    // Per-slot ROM enables from current state and address; a $CFFF access still
    // enables the owner because the release lands only at the strobe.
    always_comb begin
        SLOT_ROM_EN = 7'd0;
        for (int n = 1; n <= 7; n++) begin
            if (!intCxRom_q) begin
                if (inCn && (cnSlot == 3'(n)) && !(inC3 && !slotC3Rom_q)) begin
                    SLOT_ROM_EN[n-1] = 1'b1;
                end
                if (inC8 && (ownState_q == OWN_SLOT) && (c8Owner_q == 3'(n)) && !intC8Rom_q) begin
                    SLOT_ROM_EN[n-1] = 1'b1;
                end
            end
        end
    end

    // Internal ROM select and status-read decode.
    always_comb begin
        INT_ROM_SEL = (inCn || inC8) &&
                      (intCxRom_q || (inC3 && !slotC3Rom_q) || (inC8 && intC8Rom_q));
        STAT_VALID  = IIE_MODE && RW_N && ((ADDRESS == 16'hC015) || (ADDRESS == 16'hC017));
        STAT_BIT7   = 1'b0;
        if (STAT_VALID) begin
            STAT_BIT7 = ADDRESS[1] ? slotC3Rom_q : intCxRom_q;
        end
    end

    assign C8_OWNER  = c8Owner_q;
    assign INTC8ROM  = intC8Rom_q;
    assign INTCXROM  = intCxRom_q;
    assign SLOTC3ROM = slotC3Rom_q;

endmodule

// File: tb/tb_expansion_rom_arbiter.sv
// Scoreboard bench for expansion_rom_arbiter: a driver issues bus cycles and
// queues the response predicted by a behavioural model; a monitor compares the
// DUT outputs at each PH_2 falling edge, before that cycle's state update lands.
`timescale 1ns/1ps
module tb_expansion_rom_arbiter;

    localparam logic [6:0] MASK = 7'h02;

    logic        CLK_14M = 1'b0;
    logic        RESET   = 1'b1;
    logic        PH_2    = 1'b0;
    logic [15:0] ADDRESS = 16'h0000;
    logic        RW_N    = 1'b1;
    logic [6:0]  SLOT_ROM_EN;
    logic [2:0]  C8_OWNER;
    logic        INT_ROM_SEL, INTCXROM, SLOTC3ROM, INTC8ROM, STAT_VALID, STAT_BIT7;

    typedef struct {
        logic [15:0] addr;
        logic [15:0] exp;
    } expEntry_t;

    expEntry_t sbQueue[$];
    int vectors     = 0;
    int miscompares = 0;

    bit mIntcx, mSlotc3, mIntc8;
    int mOwner;

    expansion_rom_arbiter #(.IIE_MODE(1'b1), .SLOT_C8_MASK(MASK)) dut (
        .CLK_14M(CLK_14M), .RESET(RESET), .PH_2(PH_2), .ADDRESS(ADDRESS), .RW_N(RW_N),
        .SLOT_ROM_EN(SLOT_ROM_EN), .C8_OWNER(C8_OWNER), .INT_ROM_SEL(INT_ROM_SEL),
        .INTCXROM(INTCXROM), .SLOTC3ROM(SLOTC3ROM), .INTC8ROM(INTC8ROM),
        .STAT_VALID(STAT_VALID), .STAT_BIT7(STAT_BIT7)
    );

    always #35 CLK_14M = ~CLK_14M;

    task automatic modelReset();
        mIntcx  = 1'b0;
        mSlotc3 = 1'b0;
        mIntc8  = 1'b0;
        mOwner  = 0;
    endtask

    // Outputs expected while the access is on the bus, from the current model state.
    function automatic logic [15:0] modelResponse(input logic [15:0] a, input logic rw);
        logic [6:0] en;
        logic       inC8, intRom, sv, b7;
        int         page;
        page = int'(a[15:8]);
        inC8 = (a >= 16'hC800) && (a <= 16'hCFFF);
        en   = 7'd0;
        for (int n = 1; n <= 7; n++) begin
            if (!mIntcx) begin
                if ((page == 'hC0 + n) && !(n == 3 && !mSlotc3)) en[n-1] = 1'b1;
                if (inC8 && mOwner == n && !mIntc8) en[n-1] = 1'b1;
            end
        end
        intRom = (a >= 16'hC100) && (a <= 16'hCFFF) &&
                 (mIntcx || (page == 'hC3 && !mSlotc3) || (inC8 && mIntc8));
        sv = rw && (a == 16'hC015 || a == 16'hC017);
        b7 = sv && ((a == 16'hC015) ? mIntcx : mSlotc3);
        return {en, 3'(mOwner), intRom, mIntcx, mSlotc3, mIntc8, sv, b7};
    endfunction

    // State change caused by one completed bus cycle.
    task automatic modelUpdate(input logic [15:0] a, input logic rw);
        int n;
        n = int'(a[15:8]) - 'hC0;
        if (a == 16'hCFFF) begin
            mOwner = 0;
            mIntc8 = 1'b0;
        end else if (!rw && (a == 16'hC006 || a == 16'hC007)) begin
            mIntcx = (a == 16'hC007);
        end else if (!rw && (a == 16'hC00A || a == 16'hC00B)) begin
            mSlotc3 = (a == 16'hC00B);
        end else if (n >= 1 && n <= 7 && !mIntcx) begin
            if (n == 3 && !mSlotc3) begin
                mIntc8 = 1'b1;
                mOwner = 0;
            end else if (MASK[n-1]) begin
                mOwner = n;
                mIntc8 = 1'b0;
            end
        end
    endtask

    // One bus cycle: address set up, PH_2 high for highClks, then falling edge.
    task automatic applyStimulus(input logic [15:0] a, input logic rw,
                                 input int highClks, input bit resetAtStb);
        expEntry_t e;
        @(negedge CLK_14M);
        ADDRESS = a;
        RW_N    = rw;
        e.addr  = a;
        e.exp   = modelResponse(a, rw);
        sbQueue.push_back(e);
        if (resetAtStb) modelReset();
        else            modelUpdate(a, rw);
        @(negedge CLK_14M);
        PH_2 = 1'b1;
        repeat (highClks) @(negedge CLK_14M);
        PH_2 = 1'b0;
        if (resetAtStb) RESET = 1'b1;
        repeat (3) @(negedge CLK_14M);
        RESET = 1'b0;
    endtask

    task automatic checkOutput(input expEntry_t e, input logic [15:0] act);
        vectors++;
        if (act !== e.exp) begin
            miscompares++;
            $display("[TB] FAIL busCycle addr=%h got={en=%b own=%0d int=%b cx=%b c3=%b c8=%b sv=%b b7=%b} want={en=%b own=%0d int=%b cx=%b c3=%b c8=%b sv=%b b7=%b}",
                     e.addr, act[15:9], act[8:6], act[5], act[4], act[3], act[2], act[1], act[0],
                     e.exp[15:9], e.exp[8:6], e.exp[5], e.exp[4], e.exp[3], e.exp[2], e.exp[1], e.exp[0]);
        end
    endtask

    // Monitor: compare at each PH_2 falling edge, independent of the driver.
    initial begin : monitor
        expEntry_t e;
        forever begin
            @(posedge PH_2);
            @(negedge PH_2);
            if (sbQueue.size() == 0) begin
                vectors++;
                miscompares++;
                $display("[TB] FAIL unexpectedCycle got=queue empty want=queued entry");
            end else begin
                e = sbQueue.pop_front();
                checkOutput(e, {SLOT_ROM_EN, C8_OWNER, INT_ROM_SEL, INTCXROM,
                                SLOTC3ROM, INTC8ROM, STAT_VALID, STAT_BIT7});
            end
        end
    end

    initial begin : watchdog
        #5_000_000;
        $display("[TB] FAIL watchdog got=timeout want=finish");
        $fatal(1, "[TB] timeout");
    end

    initial begin : driver
        logic [15:0] swAddr [4];
        logic [15:0] a;
        logic        rw;
        int          kind;
        swAddr[0] = 16'hC006; swAddr[1] = 16'hC007;
        swAddr[2] = 16'hC00A; swAddr[3] = 16'hC00B;

        modelReset();
        RESET = 1'b1;
        repeat (4) @(negedge CLK_14M);
        RESET = 1'b0;

        $display("[TB] directed: claim and release");
        applyStimulus(16'hC200, 1'b1, 4, 1'b0);
        applyStimulus(16'hC800, 1'b1, 4, 1'b0);
        applyStimulus(16'hCFFF, 1'b1, 4, 1'b0);
        applyStimulus(16'hC800, 1'b1, 4, 1'b0);

        $display("[TB] directed: INTCXROM masks ownership");
        applyStimulus(16'hC200, 1'b1, 4, 1'b0);
        applyStimulus(16'hC007, 1'b0, 4, 1'b0);
        applyStimulus(16'hC200, 1'b1, 4, 1'b0);
        applyStimulus(16'hC800, 1'b1, 4, 1'b0);
        applyStimulus(16'hC006, 1'b0, 4, 1'b0);
        applyStimulus(16'hC200, 1'b1, 4, 1'b0);
        applyStimulus(16'hC800, 1'b1, 4, 1'b0);

        $display("[TB] directed: internal C8 via slot 3");
        applyStimulus(16'hC300, 1'b1, 4, 1'b0);
        applyStimulus(16'hC900, 1'b1, 4, 1'b0);
        applyStimulus(16'hC00B, 1'b0, 4, 1'b0);
        applyStimulus(16'hC300, 1'b1, 4, 1'b0);
        applyStimulus(16'hC200, 1'b1, 4, 1'b0);
        applyStimulus(16'hC800, 1'b1, 4, 1'b0);

        $display("[TB] directed: unmasked slot and long PH_2");
        applyStimulus(16'hC500, 1'b1, 4, 1'b0);
        applyStimulus(16'hC800, 1'b1, 4, 1'b0);
        applyStimulus(16'hCFFF, 1'b0, 20, 1'b0);
        applyStimulus(16'hC800, 1'b1, 4, 1'b0);

        $display("[TB] directed: reset at strobe and status reads");
        applyStimulus(16'hC200, 1'b1, 4, 1'b0);
        applyStimulus(16'hC00B, 1'b0, 4, 1'b0);
        applyStimulus(16'hC200, 1'b1, 4, 1'b1);
        applyStimulus(16'hC800, 1'b1, 4, 1'b0);
        applyStimulus(16'hC007, 1'b0, 4, 1'b0);
        applyStimulus(16'hC015, 1'b1, 4, 1'b0);
        applyStimulus(16'hC017, 1'b1, 4, 1'b0);
        applyStimulus(16'hC00B, 1'b0, 4, 1'b0);
        applyStimulus(16'hC017, 1'b1, 4, 1'b0);
        applyStimulus(16'hC006, 1'b1, 4, 1'b0);
        applyStimulus(16'hC015, 1'b1, 4, 1'b0);
        applyStimulus(16'hC006, 1'b0, 4, 1'b0);
        applyStimulus(16'hC015, 1'b1, 4, 1'b0);

        $display("[TB] random bus cycles");
        for (int i = 0; i < 300; i++) begin
            kind = $urandom_range(0, 9);
            rw   = 1'($urandom_range(0, 1));
            case (kind)
                0, 1: a = {5'b11000, 3'($urandom_range(1, 7)), 8'($urandom)};
                2:    a = {5'b11001, 11'($urandom)};
                3:    a = 16'hCFFF;
                4: begin
                    a  = swAddr[$urandom_range(0, 3)];
                    rw = ($urandom_range(0, 3) == 0);
                end
                5:    a = ($urandom_range(0, 1) == 0) ? 16'hC015 : 16'hC017;
                6:    a = {8'hC3, 8'($urandom)};
                7:    a = {8'hC2, 8'($urandom)};
                8:    a = 16'hC800;
                default: a = 16'($urandom);
            endcase
            applyStimulus(a, rw, $urandom_range(2, 6), ($urandom_range(0, 40) == 0));
        end

        repeat (4) @(negedge CLK_14M);
        vectors++;
        if (sbQueue.size() != 0) begin
            miscompares++;
            $display("[TB] FAIL drain got=%0d pending want=0 pending", sbQueue.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
